serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder: the addition counterpart to the full subtractor, built
//  around a single full-adder cell plus a carry flip-flop. Accepts two operands on
//  a start strobe, processes one bit per clock LSB-first, then presents sum/cout
//  with a one-cycle done pulse. Used where area matters more than latency.
// PARAMETERS
//  N        8   operand/sum width in bits; legal range N >= 2
// PORTS
//  clk      in   1   rising-edge clock, sole clock domain
//  rst      in   1   asynchronous, active-high reset
//  start    in   1   request; sampled only in IDLE
//  a        in   N   minuend-side operand (augend), captured on accepted start
//  b        in   N   addend, captured on accepted start
//  busy     out  1   high while in SHIFT
//  done     out  1   one-cycle pulse: sum/cout valid and new
//  sum      out  N   registered result a+b mod 2^N; holds until next completion
//  cout     out  1   registered carry out of bit N-1; holds with sum
// BEHAVIOUR
//  Reset: asynchronous, active-high; state=IDLE, busy=0, done=0, sum=0, cout=0,
//   internal shift regs, carry FF and bit counter cleared. Takes effect immediately.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : start=1 at edge -> load a_sh=a, b_sh=b, carry=0, cnt=0; go SHIFT.
//          start=0 -> stay.
//   SHIFT: each edge: s=a_sh[0]^b_sh[0]^carry;
//          carry<=(a_sh[0]&b_sh[0])|(carry&(a_sh[0]^b_sh[0]));
//          s_sh<={s,s_sh[N-1:1]}; a_sh,b_sh shift right; cnt<=cnt+1.
//          On edge with cnt==N-1: sum<=final s_sh, cout<=new carry; go DONE.
//   DONE : done=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  Latency: start accepted at edge E0 -> N bit-edges E1..EN -> done high in
//   cycle following EN (N+1 edges after E0). Throughput: one op per N+2 cycles.
//  busy=1 only in SHIFT; done=1 only in DONE; never both high.
//  start while busy or in DONE: ignored, no queuing; a/b changes after E0
//   have no effect on the running operation.
//  sum/cout updated only on completion edge; stable during following operation.
//  Overflow: sum wraps mod 2^N; carry reported solely on cout.
//  cnt width $clog2(N); compare against N-1, no reliance on counter wrap.
//  rst mid-operation: operation aborted, no done pulse, outputs cleared to 0.
// TESTING
//  1 N=8, a=00,b=00, start 1 cycle -> busy 8 cycles, done at E0+9, sum=00 cout=0.
//  2 a=FF,b=01 -> sum=00 cout=1; a=C8,b=64 -> sum=2C cout=1; a=5A,b=3C -> 96/0.
//  3 start held high throughout, a/b randomised after E0 -> result uses E0
//    values; start in DONE ignored; next op starts from IDLE 1 cycle later.
//  4 rst asserted during 4th SHIFT cycle (async, mid-cycle) -> busy/done/sum/cout
//    0 at once, no done; subsequent a=12,b=34 -> sum=46 cout=0.
//  5 N=4 exhaustive 256 pairs back-to-back -> {cout,sum}==a+b, done exactly once
//    per op, N+1 edges after accept; scoreboard checks sum held between ops.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flip-flop, LSB first.
// Operands are captured on an accepted start; the result appears with a one-cycle
// done pulse N+1 edges later and holds until the next completion.
module serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   s_sh;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic           bit_s;
  logic           bit_c;
  logic [N-1:0]   s_next;

  // Full-adder cell on the current LSBs and the stored carry
  always_comb begin
    bit_s  = a_sh[0] ^ b_sh[0] ^ carry;
    bit_c  = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    s_next = {bit_s, s_sh[N-1:1]};
  end

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          carry <= bit_c;
          s_sh  <= s_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            sum   <= s_next;
            cout  <= bit_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: N=8 directed vectors and corner sequences,
// plus an N=4 instance swept exhaustively back-to-back.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [3:0] sum4;
  logic       cout4;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;
  logic [7:0]  prev_sum8;
  logic [3:0]  prev_sum4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  serial_adder #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One N=8 operation from IDLE: checks busy, held sum, latency, result, single pulse
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] es, input logic ec, input string tag);
    bit seen = 1'b0;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge clk);
      if (done8) begin
        chk({tag, " latency"}, 32'(c), 32'd9);
        chk({tag, " busy_at_done"}, 32'(busy8), 32'd0);
        chk({tag, " sum"}, 32'(sum8), 32'(es));
        chk({tag, " cout"}, 32'(cout8), 32'(ec));
        seen = 1'b1;
        break;
      end
      chk({tag, " busy"}, 32'(busy8), (c <= 8) ? 32'd1 : 32'd0);
      chk({tag, " sum_held"}, 32'(sum8), 32'(prev_sum8));
    end
    if (!seen) chk({tag, " done_timeout"}, 32'd0, 32'd1);
    prev_sum8 = es;
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done8), 32'd0);
  endtask

  // One N=4 operation from IDLE, same checks at N=4 latency
  task automatic run4(input logic [3:0] av, input logic [3:0] bv);
    bit         seen = 1'b0;
    logic [4:0] e;
    e = 5'(av) + 5'(bv);
    a4 = av; b4 = bv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (done4) begin
        chk("n4 latency", 32'(c), 32'd5);
        chk("n4 sum", 32'(sum4), 32'(e[3:0]));
        chk("n4 cout", 32'(cout4), 32'(e[4]));
        seen = 1'b1;
        break;
      end
      chk("n4 busy", 32'(busy4), (c <= 4) ? 32'd1 : 32'd0);
      chk("n4 sum_held", 32'(sum4), 32'(prev_sum4));
    end
    if (!seen) chk("n4 done_timeout", 32'd0, 32'd1);
    prev_sum4 = e[3:0];
    @(negedge clk);
    chk("n4 done_one_cycle", 32'(done4), 32'd0);
  endtask

  initial begin
    int done_seen;
    bit seen;

    vecs[0] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hC8, b: 8'h64, sum: 8'h2C, cout: 1'b1};
    vecs[3] = '{a: 8'h5A, b: 8'h3C, sum: 8'h96, cout: 1'b0};
    vecs[4] = '{a: 8'h12, b: 8'h34, sum: 8'h46, cout: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};
    vecs[6] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1};
    vecs[7] = '{a: 8'h0F, b: 8'hF0, sum: 8'hFF, cout: 1'b0};

    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    prev_sum8 = '0; prev_sum4 = '0;
    #1;
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset sum", 32'(sum8), 32'd0);
    chk("reset cout", 32'(cout8), 32'd0);
    chk("reset n4 sum", 32'(sum4), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed N=8 vectors
    for (int i = 0; i < 8; i++) run8(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, $sformatf("vec%0d", i));

    // start held high, operands scrambled after accept, start ignored in DONE
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (done8) begin
        chk("hold latency", 32'(c), 32'd9);
        chk("hold sum", 32'(sum8), 32'hFF);
        chk("hold cout", 32'(cout8), 32'd0);
        seen = 1'b1;
        break;
      end
      chk("hold busy", 32'(busy8), 32'd1);
    end
    if (!seen) chk("hold done_timeout", 32'd0, 32'd1);
    a8 = 8'h01; b8 = 8'h02;
    @(negedge clk);
    chk("done_ignores_start busy", 32'(busy8), 32'd0);
    chk("done_ignores_start done", 32'(done8), 32'd0);
    @(negedge clk);
    chk("restart from idle busy", 32'(busy8), 32'd1);
    start8 = 1'b0;
    seen = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (done8) begin
        chk("restart latency", 32'(c), 32'd9);
        chk("restart sum", 32'(sum8), 32'h03);
        chk("restart cout", 32'(cout8), 32'd0);
        seen = 1'b1;
        break;
      end
      chk("restart sum_held", 32'(sum8), 32'hFF);
    end
    if (!seen) chk("restart done_timeout", 32'd0, 32'd1);
    prev_sum8 = 8'h03;
    @(negedge clk);

    // Asynchronous reset in the 4th SHIFT cycle
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst busy", 32'(busy8), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst done", 32'(done8), 32'd0);
    chk("midrst sum", 32'(sum8), 32'd0);
    chk("midrst cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_sum8 = '0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) done_seen++;
    end
    chk("postrst no_activity", 32'(done_seen), 32'd0);
    chk("postrst sum", 32'(sum8), 32'd0);
    run8(8'h12, 8'h34, 8'h46, 1'b0, "after_rst");

    // N=4 exhaustive, back-to-back
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run4(4'(x), 4'(y));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
